// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 32-bit integer core front end.
// Holds the opcode map, instruction field bit positions and the fetch/issue
// state encoding used by instr_fetch_issue.
package cpu_isa_pkg;

   localparam int unsigned INSTR_W = 32;

   // Opcode map as seen by the control decoder
   localparam logic [7:0] OPC_ADD   = 8'd0;
   localparam logic [7:0] OPC_SUB   = 8'd1;
   localparam logic [7:0] OPC_AND   = 8'd2;
   localparam logic [7:0] OPC_OR    = 8'd3;
   localparam logic [7:0] OPC_MOV   = 8'd4;
   localparam logic [7:0] OPC_LOADI = 8'd5;
   localparam logic [7:0] OPC_J     = 8'd6;
   localparam logic [7:0] OPC_BEQ   = 8'd7;
   localparam logic [7:0] OPC_ROR   = 8'd8;
   localparam logic [7:0] OPC_SLL   = 8'd9;
   localparam logic [7:0] OPC_SRL   = 8'd10;
   localparam logic [7:0] OPC_SRA   = 8'd11;
   localparam logic [7:0] OPC_BNE   = 8'd12;
   localparam logic [7:0] OPC_MULT  = 8'd13;
   // Falls into the decoder's default case: no write-back, no control flow
   localparam logic [7:0] OPC_NOP   = 8'hFF;

   // Instruction field positions
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 24;
   localparam int unsigned RD_MSB  = 23;
   localparam int unsigned RD_LSB  = 16;
   localparam int unsigned RS1_MSB = 15;
   localparam int unsigned RS1_LSB = 8;
   localparam int unsigned IMM_MSB = 7;
   localparam int unsigned IMM_LSB = 0;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_issue_if.sv
// Instruction memory / I-cache read handshake.
//   imem_addr      fetch address (word aligned)
//   imem_read      fetch request
//   imem_readdata  instruction word, valid when imem_read=1 and imem_busywait=0
//   imem_busywait  memory not ready
// master: the fetch unit; slave: the memory.
interface instr_fetch_issue_if
   import cpu_isa_pkg::*;
#(
   parameter int unsigned PC_W = 32
);
   logic [PC_W-1:0]    imem_addr;
   logic               imem_read;
   logic [INSTR_W-1:0] imem_readdata;
   logic               imem_busywait;

   modport master (
      output imem_addr,
      output imem_read,
      input  imem_readdata,
      input  imem_busywait
   );

   modport slave (
      input  imem_addr,
      input  imem_read,
      output imem_readdata,
      output imem_busywait
   );
endinterface

// File: rtl/instr_fetch_issue_pc_next_calc.sv
// Combinational next-PC computation.
//   pc        address of the current instruction
//   rd        rd field, reused as signed word offset for j/beq/bne
//   jump, branch, bne, zero  decoder controls and ALU zero flag
//   next_pc   address of the instruction after this one retires
//   pc_plus4  sequential successor
// Arithmetic wraps modulo 2^PC_W.
module pc_next_calc #(
   parameter int unsigned PC_W = 32
) (
   input  logic [PC_W-1:0] pc,
   input  logic [7:0]      rd,
   input  logic            jump,
   input  logic            branch,
   input  logic            bne,
   input  logic            zero,
   output logic [PC_W-1:0] next_pc,
   output logic [PC_W-1:0] pc_plus4
);
   logic [PC_W-1:0] offset;
   logic            taken;

   // Signed word offset: sign-extend rd, then scale by 4
   assign offset   = {{(PC_W - 10){rd[7]}}, rd, 2'b00};
   assign pc_plus4 = pc + PC_W'(4);
   // Jump wins over any branch condition
   assign taken    = jump | (branch & zero) | (bne & ~zero);
   assign next_pc  = taken ? (pc_plus4 + offset) : pc_plus4;
endmodule

// File: rtl/instr_fetch_issue.sv
// Unpipelined fetch/issue front end. Fetches one instruction word over the
// imem handshake, holds it in IR while issued, and advances pc on retire.
//   CLK, RESET_N   clock, asynchronous active-low reset
//   imem           instruction memory handshake (master side)
//   stall          back-end stall, holds the issued instruction
//   jump, branch, bne, zero  decoder controls / ALU zero for next-PC
//   opcode, rd, rs1, rs2_imm instruction fields (opcode is NOP when idle)
//   instr_valid    an instruction is being issued
//   pc, pc_plus4   current instruction address and its successor
// All outputs come from state, IR or pc registers only.
module instr_fetch_issue
   import cpu_isa_pkg::*;
#(
   parameter int unsigned    PC_W       = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [7:0]     NOP_OPCODE = OPC_NOP
) (
   input  logic                CLK,
   input  logic                RESET_N,
   instr_fetch_issue_if.master imem,
   input  logic                stall,
   input  logic                jump,
   input  logic                branch,
   input  logic                bne,
   input  logic                zero,
   output logic [7:0]          opcode,
   output logic [7:0]          rd,
   output logic [7:0]          rs1,
   output logic [7:0]          rs2_imm,
   output logic                instr_valid,
   output logic [PC_W-1:0]     pc,
   output logic [PC_W-1:0]     pc_plus4
);
   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    next_pc;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= BOOT;
         ir_q    <= {NOP_OPCODE, 24'h00_0000};
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      pc_d           = pc_q;
      imem.imem_read = 1'b0;
      instr_valid    = 1'b0;
      opcode         = NOP_OPCODE;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            imem.imem_read = 1'b1;
            if (!imem.imem_busywait) begin
               ir_d    = imem.imem_readdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // busywait is deliberately ignored here
            instr_valid = 1'b1;
            opcode      = ir_q[OPC_MSB:OPC_LSB];
            if (!stall) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   assign rd             = ir_q[RD_MSB:RD_LSB];
   assign rs1            = ir_q[RS1_MSB:RS1_LSB];
   assign rs2_imm        = ir_q[IMM_MSB:IMM_LSB];
   assign pc             = pc_q;
   assign imem.imem_addr = pc_q;

   pc_next_calc #(
      .PC_W(PC_W)
   ) u_pc_next_calc (
      .pc      (pc_q),
      .rd      (ir_q[RD_MSB:RD_LSB]),
      .jump    (jump),
      .branch  (branch),
      .bne     (bne),
      .zero    (zero),
      .next_pc (next_pc),
      .pc_plus4(pc_plus4)
   );
endmodule

// File: tb/tb_instr_fetch_issue.sv
module tb_instr_fetch_issue;
   import cpu_isa_pkg::*;

   localparam int K_NONE = 0;
   localparam int K_J    = 1;
   localparam int K_BEQ  = 2;
   localparam int K_BNE  = 3;
   localparam int K_JBR  = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        stall = 1'b0, jump = 1'b0, branch = 1'b0, bne = 1'b0, zero = 1'b0;
   logic [7:0]  opcode, rd, rs1, rs2_imm;
   logic        instr_valid;
   logic [31:0] pc, pc_plus4;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t        exp_q[$];
   logic [31:0] model_pc;

   instr_fetch_issue_if #(.PC_W(32)) imem ();

   instr_fetch_issue #(
      .PC_W      (32),
      .RESET_PC  (32'h0000_0000),
      .NOP_OPCODE(8'hFF)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .imem       (imem),
      .stall      (stall),
      .jump       (jump),
      .branch     (branch),
      .bne        (bne),
      .zero       (zero),
      .opcode     (opcode),
      .rd         (rd),
      .rs1        (rs1),
      .rs2_imm    (rs2_imm),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Deliver one instruction word and retire it. Entered and left at a negedge.
   task automatic run_instr(input logic [31:0] w, input int kind, input bit z,
                            input int nwait, input int nstall);
      int guard = 0;
      int off;
      bit taken;
      while (imem.imem_read !== 1'b1 && guard < 8) begin
         @(negedge CLK);
         guard++;
      end
      if (imem.imem_read !== 1'b1) begin
         chk("fetch_timeout", {31'b0, imem.imem_read}, 32'd1);
         return;
      end
      chk("fetch_addr", imem.imem_addr, model_pc);
      for (int i = 0; i < nwait; i++) begin
         imem.imem_busywait = 1'b1;
         imem.imem_readdata = $urandom;
         @(negedge CLK);
         chk("wait_read", {31'b0, imem.imem_read}, 32'd1);
         chk("wait_addr", imem.imem_addr, model_pc);
      end
      imem.imem_busywait = 1'b0;
      imem.imem_readdata = w;
      exp_q.push_back('{pc: model_pc, instr: w});
      @(negedge CLK);
      imem.imem_readdata = $urandom;
      imem.imem_busywait = 1'($urandom_range(0, 1));
      jump   = (kind == K_J) || (kind == K_JBR);
      branch = (kind == K_BEQ) || (kind == K_JBR);
      bne    = (kind == K_BNE);
      zero   = z;
      for (int i = 0; i < nstall; i++) begin
         stall = 1'b1;
         @(negedge CLK);
      end
      stall = 1'b0;
      taken = jump || (branch && z) || (bne && !z);
      off   = taken ? int'($signed(w[23:16])) * 4 : 0;
      model_pc = model_pc + 32'(4 + off);
      @(negedge CLK);
      jump = 1'b0;
      branch = 1'b0;
      bne = 1'b0;
      imem.imem_busywait = 1'b1;
   endtask

   // Monitor: pops the expected instruction on each new issue and checks
   // that fields and pc stay put for every issued cycle.
   initial begin
      bit   prev_valid = 1'b0;
      exp_t cur = '{pc: 32'h0, instr: 32'hFF00_0000};
      forever begin
         @(negedge CLK);
         if (!RESET_N) begin
            prev_valid = 1'b0;
         end else begin
            if (instr_valid) begin
               if (!prev_valid) begin
                  if (exp_q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
                  else cur = exp_q.pop_front();
               end
               chk("opcode", {24'b0, opcode}, {24'b0, cur.instr[31:24]});
               chk("rd", {24'b0, rd}, {24'b0, cur.instr[23:16]});
               chk("rs1", {24'b0, rs1}, {24'b0, cur.instr[15:8]});
               chk("rs2_imm", {24'b0, rs2_imm}, {24'b0, cur.instr[7:0]});
               chk("pc", pc, cur.pc);
               chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
            end else begin
               chk("idle_opcode", {24'b0, opcode}, 32'h0000_00FF);
            end
            prev_valid = instr_valid;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [7:0]  op;
      int          kind;
      imem.imem_busywait = 1'b1;
      imem.imem_readdata = 32'h0;
      model_pc = 32'h0;

      // Reset state
      #3;
      chk("rst_pc", pc, 32'h0);
      chk("rst_read", {31'b0, imem.imem_read}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_opcode", {24'b0, opcode}, 32'h0000_00FF);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      chk("boot_read", {31'b0, imem.imem_read}, 32'd0);
      @(negedge CLK);
      chk("first_read", {31'b0, imem.imem_read}, 32'd1);
      chk("first_addr", imem.imem_addr, 32'h0);

      // Directed flow and branches
      run_instr(32'h0502_002A, K_NONE, 1'b0, 0, 0);
      chk("seq_pc4", imem.imem_addr, 32'd4);
      run_instr(32'h0003_0201, K_NONE, 1'b0, 3, 2);
      chk("seq_pc8", imem.imem_addr, 32'd8);
      run_instr(32'h07FE_0102, K_BEQ, 1'b1, 0, 0);
      chk("beq_taken", imem.imem_addr, 32'd4);
      run_instr(32'h0003_0201, K_NONE, 1'b0, 1, 0);
      run_instr(32'h07FE_0102, K_BEQ, 1'b0, 0, 1);
      chk("beq_not_taken", imem.imem_addr, 32'd12);
      run_instr(32'h06FE_0000, K_J, 1'b0, 0, 0);
      chk("jump_back", imem.imem_addr, 32'd8);
      run_instr(32'h0CFE_0102, K_BNE, 1'b0, 2, 0);
      chk("bne_taken", imem.imem_addr, 32'd4);
      run_instr(32'h0003_0201, K_NONE, 1'b0, 0, 0);
      run_instr(32'h0603_0000, K_J, 1'b1, 0, 1);
      chk("jump_fwd", imem.imem_addr, 32'd24);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         kind = $urandom_range(0, 4);
         unique case (kind)
            K_J, K_JBR: op = OPC_J;
            K_BEQ:      op = OPC_BEQ;
            K_BNE:      op = OPC_BNE;
            default: begin
               do op = 8'($urandom_range(0, 255));
               while (op == OPC_J || op == OPC_BEQ || op == OPC_BNE);
            end
         endcase
         w = {op, 24'($urandom)};
         run_instr(w, kind, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 2));
      end
      chk("queue_drained", exp_q.size(), 32'd0);

      // Asynchronous reset in the middle of a fetch
      imem.imem_busywait = 1'b1;
      @(negedge CLK);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("midfetch_read", {31'b0, imem.imem_read}, 32'd0);
      chk("midfetch_pc", pc, 32'h0);
      chk("midfetch_valid", {31'b0, instr_valid}, 32'd0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      model_pc = 32'h0;

      // Wrap from 0xFFFF_FFFC back to 0
      run_instr(32'h06FE_0000, K_J, 1'b0, 0, 0);
      chk("wrap_pre", imem.imem_addr, 32'hFFFF_FFFC);
      run_instr(32'h0003_0201, K_NONE, 1'b1, 1, 1);
      chk("wrap_post", imem.imem_addr, 32'h0);
      repeat (2) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
